// File: rtl/isa_pkg.sv
// Shared ISA definitions for the issue stage:
// opcodes, FSM states and field widths.
package isa_pkg;

    localparam int XLEN   = 8;
    localparam int OP_W   = 3;
    localparam int REG_AW = 2;

    localparam logic [OP_W-1:0] OP_LOGIC = 3'b000;
    localparam logic [OP_W-1:0] OP_LI    = 3'b001;
    localparam logic [OP_W-1:0] OP_ARITH = 3'b011;
    localparam logic [OP_W-1:0] OP_SHIFT = 3'b100;
    localparam logic [OP_W-1:0] OP_NOP   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IMM  = 2'd1,
        EXEC = 2'd2
    } state_t;

endpackage

// File: rtl/reg_file_4x8.sv
// Register file: two combinational operand ports,
// one debug read port, one synchronous write port.
module reg_file_4x8
    import isa_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] rf [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    assign rd1      = rf[ra1];
    assign rd2      = rf[ra2];
    assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/issue_stage.sv
// Decode-and-issue stage feeding an external 8-bit ALU,
// with a two-byte load-immediate handled locally.
module issue_stage
    import isa_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [7:0] alu_rs1,
    output logic [7:0] alu_rs2,
    output logic [2:0] alu_ctrl,
    output logic       alu_flag,
    input  logic [7:0] alu_out,
    input  logic       alu_overflow,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [7:0] wb_data,
    output logic       ovf_flag,
    output logic       illegal,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data
);

    state_t state_q, state_d;

    logic [OP_W-1:0]   op_q;
    logic              flag_q;
    logic [REG_AW-1:0] rd_q, rs_q;

    logic [OP_W-1:0]   op_in;
    logic              accept;
    logic              latch_en;
    logic              ill_d;
    logic              ovf_d;
    logic              in_exec;

    logic              rf_we;
    logic [XLEN-1:0]   rf_wd;
    logic [XLEN-1:0]   rf_rd1, rf_rd2;

    assign op_in       = instr[7:5];
    assign in_exec     = (state_q == EXEC);
    assign instr_ready = !rst && !in_exec;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d  = state_q;
        rf_we    = 1'b0;
        rf_wd    = instr;
        ill_d    = 1'b0;
        ovf_d    = ovf_flag;
        latch_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    latch_en = 1'b1;
                    unique case (1'b1)
                        (op_in == OP_LOGIC),
                        (op_in == OP_ARITH),
                        (op_in == OP_SHIFT): state_d = EXEC;
                        (op_in == OP_LI):    state_d = IMM;
                        default:             ill_d   = 1'b1;
                    endcase
                end
            end
            IMM: begin
                if (accept) begin
                    rf_we   = 1'b1;
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rf_we   = 1'b1;
                rf_wd   = alu_out;
                ovf_d   = alu_overflow;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            flag_q   <= 1'b0;
            rd_q     <= '0;
            rs_q     <= '0;
            ovf_flag <= 1'b0;
            illegal  <= 1'b0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            state_q  <= state_d;
            ovf_flag <= ovf_d;
            illegal  <= ill_d;
            wb_valid <= rf_we;
            if (latch_en) begin
                op_q   <= op_in;
                flag_q <= instr[4];
                rd_q   <= instr[3:2];
                rs_q   <= instr[1:0];
            end
            if (rf_we) begin
                wb_rd   <= rd_q;
                wb_data <= rf_wd;
            end
        end
    end

    // ALU sees idle operands and a NOP outside EXEC so it outputs zero.
    assign alu_rs1  = in_exec ? rf_rd1 : '0;
    assign alu_rs2  = in_exec ? rf_rd2 : '0;
    assign alu_ctrl = in_exec ? op_q : OP_NOP;
    assign alu_flag = in_exec ? flag_q : 1'b0;

    reg_file_4x8 #(
        .NREG(NREG)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .ra1     (rd_q),
        .ra2     (rs_q),
        .rd1     (rf_rd1),
        .rd2     (rf_rd2),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .we      (rf_we),
        .wa      (rd_q),
        .wd      (rf_wd)
    );

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage with a behavioural
// 8-bit ALU attached to the ALU ports.
module tb_issue_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_ready;
    logic [7:0] alu_rs1, alu_rs2;
    logic [2:0] alu_ctrl;
    logic       alu_flag;
    logic [7:0] alu_out;
    logic       alu_overflow;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       ovf_flag;
    logic       illegal;
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_stage #(.NREG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_ctrl    (alu_ctrl),
        .alu_flag    (alu_flag),
        .alu_out     (alu_out),
        .alu_overflow(alu_overflow),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ovf_flag    (ovf_flag),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Reference ALU: carry out of the 9-bit sum is the overflow.
    logic [8:0] sum;
    always_comb begin
        sum          = 9'd0;
        alu_out      = 8'h00;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            3'b000: alu_out = alu_flag ? ~(alu_rs1 & alu_rs2)
                                       : ~(alu_rs1 | alu_rs2);
            3'b011: begin
                if (alu_flag)
                    sum = {1'b0, alu_rs1} + {1'b0, ~alu_rs2} + 9'd1;
                else
                    sum = {1'b0, alu_rs1} + {1'b0, alu_rs2};
                alu_out      = sum[7:0];
                alu_overflow = sum[8];
            end
            3'b100: alu_out = alu_flag ? (alu_rs1 << alu_rs2[2:0])
                                       : (alu_rs1 >> alu_rs2[2:0]);
            default: alu_out = 8'h00;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        instr_valid = 1'b1;
        instr       = b;
        tick();
        instr_valid = 1'b0;
        instr       = 8'h00;
    endtask

    task automatic li(input logic [1:0] r, input logic [7:0] v);
        send({3'b001, 1'b0, r, 2'b00});
        send(v);
    endtask

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic peek(input logic [1:0] r, output logic [7:0] v);
        dbg_addr = r;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got %b want 0", instr_ready);
        end
        checks++;
        if (alu_ctrl !== 3'b111) begin
            errors++;
            $display("FAIL rst_ctrl: got %b want 111", alu_ctrl);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_ready: got %b want 1", instr_ready);
        end
        checks++;
        if ({wb_valid, ovf_flag, illegal} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags: got %b want 000",
                     {wb_valid, ovf_flag, illegal});
        end
        for (int i = 0; i < 4; i++) begin
            peek(i[1:0], v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL rst_rf%0d: got %h want 00", i, v);
            end
        end
        checks++;
        if ({alu_rs1, alu_rs2, alu_flag} !== 17'd0) begin
            errors++;
            $display("FAIL rst_alu: got %h %h %b want 0",
                     alu_rs1, alu_rs2, alu_flag);
        end
    endtask

    task automatic test_li();
        logic [7:0] v;
        send(8'h24);
        checks++;
        if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL li_imm_wait: got wbv=%b rdy=%b want 0 1",
                     wb_valid, instr_ready);
        end
        send(8'h0F);
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL li_wbv: got %b want 1", wb_valid);
        end
        chk("li_wb_rd", {6'd0, wb_rd}, 8'h01);
        chk("li_wb_data", wb_data, 8'h0F);
        peek(2'd1, v);
        chk("li_r1", v, 8'h0F);
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL li_wbv_pulse: got %b want 0", wb_valid);
        end
    endtask

    task automatic test_li_gap();
        logic [7:0] v;
        li(2'd1, 8'h55);
        send(8'h24);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_ready !== 1'b1 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_wait%0d: got rdy=%b wbv=%b want 1 0",
                         i, instr_ready, wb_valid);
            end
        end
        send(8'h0F);
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_wbv: got %b want 1", wb_valid);
        end
        chk("gap_wb_data", wb_data, 8'h0F);
        peek(2'd1, v);
        chk("gap_r1", v, 8'h0F);
    endtask

    task automatic test_add();
        logic [7:0] v;
        li(2'd1, 8'hF0);
        li(2'd2, 8'h20);
        send(8'h66);
        chk("add_rs1", alu_rs1, 8'hF0);
        chk("add_rs2", alu_rs2, 8'h20);
        chk("add_ctrl", {5'd0, alu_ctrl}, 8'h03);
        checks++;
        if (alu_flag !== 1'b0 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: got flag=%b rdy=%b want 0 0",
                     alu_flag, instr_ready);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || ovf_flag !== 1'b1
            || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_wb: got wbv=%b ovf=%b rdy=%b want 1 1 1",
                     wb_valid, ovf_flag, instr_ready);
        end
        chk("add_wb_data", wb_data, 8'h10);
        chk("add_wb_rd", {6'd0, wb_rd}, 8'h01);
        peek(2'd1, v);
        chk("add_r1", v, 8'h10);
        chk("add_ctrl_idle", {5'd0, alu_ctrl}, 8'h07);
        li(2'd2, 8'h20);
        checks++;
        if (ovf_flag !== 1'b1) begin
            errors++;
            $display("FAIL li_keeps_ovf: got %b want 1", ovf_flag);
        end
    endtask

    task automatic test_sub_shift();
        logic [7:0] v;
        send(8'h76);
        chk("sub_ctrl", {4'd0, alu_ctrl, alu_flag}, 8'h07);
        tick();
        chk("sub_wb_data", wb_data, 8'hF0);
        checks++;
        if (ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL sub_ovf: got %b want 0", ovf_flag);
        end
        li(2'd2, 8'h02);
        send(8'h96);
        chk("shl_ops", alu_rs2, 8'h02);
        chk("shl_ctrl", {4'd0, alu_ctrl, alu_flag}, 8'h09);
        tick();
        chk("shl_wb_data", wb_data, 8'hC0);
        peek(2'd1, v);
        chk("shl_r1", v, 8'hC0);
        checks++;
        if (ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL shl_ovf: got %b want 0", ovf_flag);
        end
        // back-to-back: NAND r1,r2 right after the shift writes back
        send(8'h16);
        tick();
        chk("nand_wb_data", wb_data, 8'hFF);
        send(8'h06);
        tick();
        chk("nor_wb_data", wb_data, 8'h00);
        send(8'h86);
        tick();
        chk("shr_wb_data", wb_data, 8'h00);
    endtask

    task automatic test_illegal();
        send(8'h40);
        checks++;
        if (illegal !== 1'b1 || wb_valid !== 1'b0
            || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ill_pulse: got ill=%b wbv=%b rdy=%b want 1 0 1",
                     illegal, wb_valid, instr_ready);
        end
        tick();
        checks++;
        if (illegal !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL ill_end: got ill=%b wbv=%b want 0 0",
                     illegal, wb_valid);
        end
        send(8'hE5);
        checks++;
        if (illegal !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL ill_111: got ill=%b wbv=%b want 1 0",
                     illegal, wb_valid);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] v;
        li(2'd3, 8'h77);
        send(8'h2C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_imm: got wbv=%b rdy=%b want 0 1",
                     wb_valid, instr_ready);
        end
        peek(2'd3, v);
        chk("abort_r3", v, 8'h00);
        send(8'h40);
        checks++;
        if (illegal !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_decode: got ill=%b wbv=%b want 1 0",
                     illegal, wb_valid);
        end
        li(2'd1, 8'h05);
        send(8'h66);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tick();
        checks++;
        if (wb_valid !== 1'b0 || ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL abort_exec: got wbv=%b ovf=%b want 0 0",
                     wb_valid, ovf_flag);
        end
        peek(2'd1, v);
        chk("abort_exec_r1", v, 8'h00);
    endtask

    initial begin
        test_reset();
        test_li();
        test_li_gap();
        test_add();
        test_sub_shift();
        test_illegal();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
